// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the encode and decode pipelines:
// mode encoding, per-mode code geometry and parity-check matrices.
package ecc_pkg;

    typedef enum logic [1:0] {
        MODE_8_4     = 2'b00,
        MODE_16_11   = 2'b01,
        MODE_32_26   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } ecc_mode_e;

    localparam int CW_W   = 32;
    localparam int INFO_W = 26;
    localparam int SYND_W = 6;

    localparam int N_8_4   = 8;
    localparam int K_8_4   = 4;
    localparam int P_8_4   = 4;
    localparam int N_16_11 = 16;
    localparam int K_16_11 = 11;
    localparam int P_16_11 = 5;
    localparam int N_32_26 = 32;
    localparam int K_32_26 = 26;
    localparam int P_32_26 = 6;

    typedef logic [SYND_W-1:0][CW_W-1:0] h_mat_t;

    // Element r feeds syndrome bit r; the highest populated row is the overall-parity row.
    localparam h_mat_t H_8_4 = {32'h0, 32'h0, 32'h000000ff, 32'h000000e4,
                                32'h000000d2, 32'h000000b1};
    localparam h_mat_t H_16_11 = {32'h0, 32'h0000ffff, 32'h0000fe08, 32'h0000f1c4,
                                  32'h0000cda2, 32'h0000ab61};
    localparam h_mat_t H_32_26 = {32'hffffffff, 32'hfffe0010, 32'hff01fc08, 32'hf0f1e384,
                                  32'hcccd9b42, 32'haaab56c1};

    function automatic h_mat_t h_matrix(input ecc_mode_e m);
        case (m)
            MODE_8_4:   return H_8_4;
            MODE_16_11: return H_16_11;
            MODE_32_26: return H_32_26;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [CW_W-1:0] cw_mask(input ecc_mode_e m);
        case (m)
            MODE_8_4:   return 32'h000000ff;
            MODE_16_11: return 32'h0000ffff;
            MODE_32_26: return 32'hffffffff;
            default:    return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome of a codeword against the selected mode's parity-check matrix.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0]   cw_i,
    input  ecc_mode_e         mod_i,
    output logic [SYND_W-1:0] synd_o
);

    h_mat_t h;

    // Rows are zero above n, so padding bits never reach the syndrome.
    always_comb begin
        synd_o = '0;
        h      = h_matrix(mod_i);
        for (int r = 0; r < SYND_W; r++) begin
            synd_o[r] = ^(cw_i & h[r]);
        end
    end

endmodule

// File: rtl/ecc_dec_pipe.sv
// Two-stage SECDED decoder: S1 holds codeword and syndrome, S2 holds corrected
// info and flags; saturating error counters track words leaving S2.
module ecc_dec_pipe
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    out_mod,
    output logic                          err_corrected,
    output logic                          err_uncorrectable,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

    logic                 s1_v_q;
    logic [CW_W-1:0]      s1_cw_q;
    ecc_mode_e            s1_mod_q;
    logic [SYND_W-1:0]    s1_synd_q;
    logic                 s2_v_q;
    logic [INFO_W-1:0]    s2_data_q;
    logic [1:0]           s2_mod_q;
    logic                 s2_corr_q;
    logic                 s2_unc_q;
    logic [CNT_WIDTH-1:0] corr_q;
    logic [CNT_WIDTH-1:0] unc_q;

    ecc_mode_e         in_mod;
    logic [SYND_W-1:0] synd_d;
    logic              s2_adv;
    logic              xfer;

    assign in_mod   = ecc_mode_e'(mod);
    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_adv;
    assign xfer     = s2_v_q && out_ready;

    ecc_syndrome u_synd (
        .cw_i   (data_in),
        .mod_i  (in_mod),
        .synd_o (synd_d)
    );

    h_mat_t            h;
    logic [SYND_W-1:0] col;
    logic [CW_W-1:0]   flip;
    logic [CW_W-1:0]   cw_fix;
    logic              hit;
    logic              p_bit;
    logic              s_lo_nz;
    logic [INFO_W-1:0] data_d;
    logic              corr_d;
    logic              unc_d;

    always_comb begin
        h       = h_matrix(s1_mod_q);
        col     = '0;
        flip    = '0;
        hit     = 1'b0;
        p_bit   = 1'b0;
        s_lo_nz = 1'b0;
        data_d  = '0;
        // Columns above n are all-zero and can only match a clean syndrome, which is never corrected.
        for (int j = 0; j < CW_W; j++) begin
            for (int r = 0; r < SYND_W; r++) begin
                col[r] = h[r][j];
            end
            if (col == s1_synd_q) begin
                flip[j] = 1'b1;
                hit     = 1'b1;
            end
        end
        case (s1_mod_q)
            MODE_8_4: begin
                p_bit   = s1_synd_q[P_8_4-1];
                s_lo_nz = |s1_synd_q[P_8_4-2:0];
            end
            MODE_16_11: begin
                p_bit   = s1_synd_q[P_16_11-1];
                s_lo_nz = |s1_synd_q[P_16_11-2:0];
            end
            MODE_32_26: begin
                p_bit   = s1_synd_q[P_32_26-1];
                s_lo_nz = |s1_synd_q[P_32_26-2:0];
            end
            default: ;
        endcase
        corr_d = p_bit && hit;
        unc_d  = (s1_mod_q == MODE_ILLEGAL) || (p_bit && !hit) || (!p_bit && s_lo_nz);
        cw_fix = corr_d ? (s1_cw_q ^ flip) : s1_cw_q;
        case (s1_mod_q)
            MODE_8_4:   data_d = INFO_W'(cw_fix[N_8_4-1:P_8_4]);
            MODE_16_11: data_d = INFO_W'(cw_fix[N_16_11-1:P_16_11]);
            MODE_32_26: data_d = INFO_W'(cw_fix[N_32_26-1:P_32_26]);
            default:    data_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_cw_q   <= '0;
            s1_mod_q  <= MODE_8_4;
            s1_synd_q <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_mod_q  <= '0;
            s2_corr_q <= 1'b0;
            s2_unc_q  <= 1'b0;
            corr_q    <= '0;
            unc_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    s1_cw_q   <= data_in & cw_mask(in_mod);
                    s1_mod_q  <= in_mod;
                    s1_synd_q <= synd_d;
                end
            end
            if (s2_adv) begin
                s2_v_q    <= s1_v_q;
                s2_data_q <= s1_v_q ? data_d : '0;
                s2_mod_q  <= s1_v_q ? s1_mod_q : 2'b00;
                s2_corr_q <= s1_v_q && corr_d;
                s2_unc_q  <= s1_v_q && unc_d;
            end
            if (cnt_clr) begin
                corr_q <= '0;
            end else if (xfer && s2_corr_q && corr_q != '1) begin
                corr_q <= corr_q + CNT_WIDTH'(1);
            end
            if (cnt_clr) begin
                unc_q <= '0;
            end else if (xfer && s2_unc_q && unc_q != '1) begin
                unc_q <= unc_q + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid         = s2_v_q;
    assign data_out          = s2_data_q;
    assign out_mod           = s2_mod_q;
    assign err_corrected     = s2_corr_q;
    assign err_uncorrectable = s2_unc_q;
    assign corr_cnt          = corr_q;
    assign uncorr_cnt        = unc_q;

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Scoreboard bench for ecc_dec_pipe: directed words push expected results,
// a negedge monitor pops and compares every S2 transfer and tracks the counters.
module tb_ecc_dec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  mod;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] data_out;
    logic [1:0]  out_mod;
    logic        err_corrected;
    logic        err_uncorrectable;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    typedef struct packed {
        logic [25:0] data;
        logic [1:0]  md;
        logic        corr;
        logic        unc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_corr = 16'h0;
    logic [15:0] m_unc  = 16'h0;

    always #5 clk = ~clk;

    ecc_dec_pipe dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .data_in           (data_in),
        .mod               (mod),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .out_mod           (out_mod),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .cnt_clr           (cnt_clr),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [25:0] xd,
                        input logic xc, input logic xu);
        exp_t e;
        logic acc;
        int   n;
        e.data = xd;
        e.md   = m;
        e.corr = xc;
        e.unc  = xu;
        sb.push_back(e);
        in_valid = 1'b1;
        mod      = m;
        data_in  = d;
        n        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [29:0] held;
        logic        stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                m_corr  = 16'h0;
                m_unc   = 16'h0;
            end else begin
                chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
                chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_unc));
                if (stalled) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_hold", 32'({data_out, out_mod, err_corrected, err_uncorrectable}),
                        32'(held));
                end
                stalled = 1'b0;
                if (out_valid && !out_ready) begin
                    stalled = 1'b1;
                    held    = {data_out, out_mod, err_corrected, err_uncorrectable};
                end else if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("data_out", 32'(data_out), 32'(e.data));
                        chk("out_mod", 32'(out_mod), 32'(e.md));
                        chk("err_corrected", 32'(err_corrected), 32'(e.corr));
                        chk("err_uncorrectable", 32'(err_uncorrectable), 32'(e.unc));
                        if (e.corr && m_corr != 16'hffff) m_corr = m_corr + 16'd1;
                        if (e.unc && m_unc != 16'hffff) m_unc = m_unc + 16'd1;
                    end
                end
                if (cnt_clr) begin
                    m_corr = 16'h0;
                    m_unc  = 16'h0;
                end
            end
        end
    end

    initial begin : stim
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 32'h0;
        mod       = 2'b00;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_flags", 32'({err_corrected, err_uncorrectable}), 32'd0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Mode (8,4): clean, data error, double error, overall-bit error, nonzero pad
        send(2'b00, 32'h000000AA, 26'hA, 1'b0, 1'b0);
        send(2'b00, 32'h000000EA, 26'hA, 1'b1, 1'b0);
        send(2'b00, 32'h000000EB, 26'hE, 1'b0, 1'b1);
        send(2'b00, 32'h000000A2, 26'hA, 1'b1, 1'b0);
        send(2'b00, 32'hFFFFFFAA, 26'hA, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        chk("corr_cnt_after_mode0", 32'(corr_cnt), 32'd2);
        chk("uncorr_cnt_after_mode0", 32'(uncorr_cnt), 32'd1);

        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr", {corr_cnt, uncorr_cnt}, 32'd0);

        // Clear coincides with the S2 transfer of an uncorrectable word
        @(posedge clk);
        #1;
        send(2'b11, 32'h0000_00FF, 26'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins", 32'(uncorr_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Mixed modes with downstream stalled for several cycles
        out_ready = 1'b0;
        send(2'b00, 32'h000000AA, 26'hA, 1'b0, 1'b0);
        send(2'b01, 32'h00008033, 26'h1, 1'b1, 1'b0);
        @(negedge clk);
        chk("in_ready_full", 32'(in_ready), 32'd0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send(2'b10, 32'h00000063, 26'h1, 1'b0, 1'b0);
        join
        drain();

        send(2'b11, 32'h12345678, 26'h0, 1'b0, 1'b1);
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send(2'b00, 32'h000000EA, 26'hA, 1'b1, 1'b0);
        send(2'b00, 32'h000000EB, 26'hE, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Drive uncorr_cnt to saturation, then one more
        for (int i = 0; i < 65535; i++) begin
            send(2'b11, 32'h0, 26'h0, 1'b0, 1'b1);
        end
        drain();
        @(negedge clk);
        chk("uncorr_cnt_full", 32'(uncorr_cnt), 32'h0000FFFF);
        @(posedge clk);
        #1;
        send(2'b11, 32'h0, 26'h0, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        chk("uncorr_cnt_saturated", 32'(uncorr_cnt), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
